// File: rtl/update_stage_param.sv
// Lifting update stage: s[n] = x[2n] + ((d[n-1] + d[n] + RC) >>> SHIFT), two-stage pipeline with stall.
// Define UPDATE_SAT_EN to clip overflowing results; otherwise the result wraps to DATA_W bits.
module update_stage_param #(
  parameter int DATA_W = 16,
  parameter int SHIFT  = 2,
  parameter int ROUND  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sof,
  input  logic [DATA_W-1:0] in_even,
  input  logic [DATA_W-1:0] in_detail,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_coarse,
  output logic              out_sof,
  output logic              ovf
);

  localparam int EW = DATA_W + 2;
  localparam logic signed [EW-1:0] RC = (ROUND != 0) ? (EW'(1) << (SHIFT - 1)) : '0;
  localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  logic en;
  logic in_fire;

  logic              primed_q, primed_d;
  logic [DATA_W-1:0] dprev_q, dprev_d;

  logic              s1_valid_q, s1_valid_d;
  logic              s1_sof_q, s1_sof_d;
  logic [DATA_W-1:0] s1_even_q, s1_even_d;
  logic [DATA_W-1:0] s1_dprev_q, s1_dprev_d;
  logic [DATA_W-1:0] s1_dcur_q, s1_dcur_d;

  logic              out_valid_q, out_valid_d;
  logic              out_sof_q, out_sof_d;
  logic [DATA_W-1:0] out_coarse_q, out_coarse_d;
  logic              ovf_q, ovf_d;

  logic signed [EW-1:0] sum_ext;
  logic signed [EW-1:0] upd_ext;
  logic signed [EW-1:0] res_ext;
  logic                 res_ovf;
  logic [DATA_W-1:0]    res_coarse;

  assign en       = !out_valid_q || out_ready;
  assign in_ready = en;
  assign in_fire  = in_valid && en;

  // S1 arithmetic, all at DATA_W+2 bits so neither the sum nor the result can wrap internally.
  always_comb begin
    sum_ext = $signed({{2{s1_dprev_q[DATA_W-1]}}, s1_dprev_q})
            + $signed({{2{s1_dcur_q[DATA_W-1]}}, s1_dcur_q})
            + RC;
    upd_ext = sum_ext >>> SHIFT;
    res_ext = $signed({{2{s1_even_q[DATA_W-1]}}, s1_even_q}) + upd_ext;
    // The three top bits must agree for the result to fit in DATA_W bits.
    res_ovf = !((res_ext[EW-1:DATA_W-1] == 3'b000) || (res_ext[EW-1:DATA_W-1] == 3'b111));
`ifdef UPDATE_SAT_EN
    if (res_ovf) begin
      res_coarse = res_ext[EW-1] ? SAT_MIN : SAT_MAX;
    end else begin
      res_coarse = res_ext[DATA_W-1:0];
    end
`else
    res_coarse = res_ext[DATA_W-1:0];
`endif
  end

  always_comb begin
    primed_d     = primed_q;
    dprev_d      = dprev_q;
    s1_valid_d   = s1_valid_q;
    s1_sof_d     = s1_sof_q;
    s1_even_d    = s1_even_q;
    s1_dprev_d   = s1_dprev_q;
    s1_dcur_d    = s1_dcur_q;
    out_valid_d  = out_valid_q;
    out_sof_d    = out_sof_q;
    out_coarse_d = out_coarse_q;
    ovf_d        = ovf_q;

    if (en) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_sof_d   = in_sof;
        s1_even_d  = in_even;
        s1_dcur_d  = in_detail;
        // Start of row (or first sample after reset) mirrors d[-1] = d[0].
        s1_dprev_d = (in_sof || !primed_q) ? in_detail : dprev_q;
        dprev_d    = in_detail;
        primed_d   = 1'b1;
      end
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_sof_d    = s1_sof_q;
        out_coarse_d = res_coarse;
        ovf_d        = ovf_q || res_ovf;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      primed_q     <= 1'b0;
      dprev_q      <= '0;
      s1_valid_q   <= 1'b0;
      s1_sof_q     <= 1'b0;
      s1_even_q    <= '0;
      s1_dprev_q   <= '0;
      s1_dcur_q    <= '0;
      out_valid_q  <= 1'b0;
      out_sof_q    <= 1'b0;
      out_coarse_q <= '0;
      ovf_q        <= 1'b0;
    end else begin
      primed_q     <= primed_d;
      dprev_q      <= dprev_d;
      s1_valid_q   <= s1_valid_d;
      s1_sof_q     <= s1_sof_d;
      s1_even_q    <= s1_even_d;
      s1_dprev_q   <= s1_dprev_d;
      s1_dcur_q    <= s1_dcur_d;
      out_valid_q  <= out_valid_d;
      out_sof_q    <= out_sof_d;
      out_coarse_q <= out_coarse_d;
      ovf_q        <= ovf_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_sof    = out_sof_q;
  assign out_coarse = out_coarse_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_update_stage_param.sv
// Bench for update_stage_param: directed cases plus random traffic against an integer reference model.
module tb_update_stage_param;
  localparam int DW    = 16;
  localparam int SHIFT = 2;
  localparam int ROUND = 1;
  localparam int MAXV  = 32767;
  localparam int MINV  = -32768;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_sof = 1'b0;
  logic [DW-1:0] in_even = '0;
  logic [DW-1:0] in_detail = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_coarse;
  logic          out_sof;
  logic          ovf;

  update_stage_param #(.DATA_W(DW), .SHIFT(SHIFT), .ROUND(ROUND)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
    .in_even(in_even), .in_detail(in_detail),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_coarse(out_coarse), .out_sof(out_sof), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] coarse;
    bit            sof;
    bit            ovf;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   m_prev = 0;
  bit   m_primed = 0;
  bit   m_ovf = 0;
  bit   obs_valid;
  bit   acc;
  int   tx = 0;

  // Reference: plain integer arithmetic on the row-wise lifting rule.
  task automatic model_accept(input bit sof, input int even, input int det);
    int   dp, u, r;
    exp_t e;
    dp = (sof || !m_primed) ? det : m_prev;
    u  = (dp + det + (ROUND ? (1 << (SHIFT - 1)) : 0)) >>> SHIFT;
    r  = even + u;
    e.ovf = (r > MAXV) || (r < MINV);
`ifdef UPDATE_SAT_EN
    if (r > MAXV) r = MAXV;
    if (r < MINV) r = MINV;
`endif
    e.coarse = r[DW-1:0];
    e.sof    = sof;
    exp_q.push_back(e);
    m_prev   = det;
    m_primed = 1;
  endtask

  task automatic cyc(input bit v, input bit sof, input int even, input int det,
                     input bit ordy, output bit accepted);
    exp_t e;
    @(negedge clk);
    in_valid  = v;
    in_sof    = sof;
    in_even   = even[DW-1:0];
    in_detail = det[DW-1:0];
    out_ready = ordy;
    #1;
    obs_valid = out_valid;
    checks++;
    assert (in_ready === (!out_valid || out_ready))
      else begin errors++; $error("FAIL in_ready obs=%b exp=%b", in_ready, (!out_valid || out_ready)); end
    if (out_valid === 1'b1) begin
      checks++;
      assert (exp_q.size() != 0)
        else begin errors++; $error("FAIL spurious_out obs=valid exp=idle coarse=%0d", $signed(out_coarse)); end
      if (exp_q.size() != 0) begin
        e = exp_q[0];
        if (e.ovf) m_ovf = 1;
        checks++;
        assert (out_coarse === e.coarse)
          else begin errors++; $error("FAIL coarse obs=%0d exp=%0d", $signed(out_coarse), $signed(e.coarse)); end
        checks++;
        assert (out_sof === e.sof)
          else begin errors++; $error("FAIL sof obs=%b exp=%b", out_sof, e.sof); end
        checks++;
        assert (ovf === m_ovf)
          else begin errors++; $error("FAIL ovf obs=%b exp=%b", ovf, m_ovf); end
        $display("out tx coarse=%0d sof=%b ovf=%b ready=%b", $signed(out_coarse), out_sof, ovf, out_ready);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
    accepted = v && in_ready;
    if (accepted) begin
      model_accept(sof, even, det);
      $display("in  tx %0d sof=%b even=%0d detail=%0d", tx, sof, even, det);
      tx++;
    end
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    checks++;
    assert (in_ready === 1'b1) else begin errors++; $error("FAIL rst_in_ready obs=%b exp=1", in_ready); end
    @(posedge clk);
    #1;
    checks++;
    assert (out_valid === 1'b0) else begin errors++; $error("FAIL rst_out_valid obs=%b exp=0", out_valid); end
    checks++;
    assert (ovf === 1'b0) else begin errors++; $error("FAIL rst_ovf obs=%b exp=0", ovf); end
    checks++;
    assert (out_coarse === '0 && out_sof === 1'b0)
      else begin errors++; $error("FAIL rst_out obs=%0d/%b exp=0/0", out_coarse, out_sof); end
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    m_prev = 0; m_primed = 0; m_ovf = 0;
    $display("reset done");
  endtask

  task automatic drain();
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 1, acc);
    checks++;
    assert (exp_q.size() == 0)
      else begin errors++; $error("FAIL drain obs=%0d pending exp=0", exp_q.size()); end
  endtask

  initial begin
    int idx;
    logic [DW-1:0] rv_e, rv_d;

    do_reset();

    // Rounding, then history, with exact two-edge latency.
    cyc(1, 1, 1, 50, 1, acc);
    cyc(1, 0, 10, 100, 1, acc);
    checks++;
    assert (obs_valid == 1'b0) else begin errors++; $error("FAIL latency_early obs=%b exp=0", obs_valid); end
    cyc(0, 0, 0, 0, 1, acc);
    checks++;
    assert (obs_valid == 1'b1) else begin errors++; $error("FAIL latency_due obs=%b exp=1", obs_valid); end
    drain();

    // Negative values and overflow.
    cyc(1, 1, 0, -6, 1, acc);
    cyc(1, 1, 32767, 400, 1, acc);
    drain();
    checks++;
    assert (ovf === 1'b1) else begin errors++; $error("FAIL ovf_sticky obs=%b exp=1", ovf); end

    // Backpressure: five samples with out_ready low for three cycles.
    idx = 0;
    for (int t = 0; t < 20 && idx < 5; t++) begin
      cyc(1, idx == 0, 100 * idx - 50, 37 * idx - 90, !(t >= 2 && t < 5), acc);
      if (acc) idx++;
    end
    checks++;
    assert (idx == 5) else begin errors++; $error("FAIL bp_accept obs=%0d exp=5", idx); end
    drain();

    // Reset while output is valid, then a non-sof sample must be mirrored.
    cyc(1, 1, 3, 7, 1, acc);
    cyc(1, 0, 5, 9, 1, acc);
    cyc(0, 0, 0, 0, 0, acc);
    checks++;
    assert (obs_valid == 1'b1) else begin errors++; $error("FAIL pre_reset_valid obs=%b exp=1", obs_valid); end
    do_reset();
    cyc(1, 0, 4, 8, 1, acc);
    cyc(0, 0, 0, 0, 1, acc);
    cyc(0, 0, 0, 0, 1, acc);
    checks++;
    assert (obs_valid == 1'b1 && exp_q.size() == 0)
      else begin errors++; $error("FAIL mirror_after_reset obs=%b/%0d exp=1/0", obs_valid, exp_q.size()); end

    // Random traffic.
    for (int t = 0; t < 400; t++) begin
      rv_e = DW'($urandom);
      rv_d = DW'($urandom);
      if ($urandom_range(0, 3) == 0) rv_d = rv_d >>> 6;
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
          int'($signed(rv_e)), int'($signed(rv_d)), $urandom_range(0, 3) != 0, acc);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
